route_sequencer: RTL and testbench
==================================

# route_sequencer

Mission-level controller placed above `DirectionControl`. It consumes the 4-bit steering code from `DirectionControl` and forwards it to the motor driver during line following. It treats a sustained STOP code as an intersection or end-of-line and executes the next entry of a small programmable route table: straight, left, right, reverse, or halt. It also drives the `Direction` input of `DirectionControl`.

## Interface
- `ROUTE_LEN`, 8: route table depth. Power of two, 2..16.
- `SETTLE_TICKS`, 100_000: consecutive STOP cycles required to declare an intersection.
- `TURN_TICKS`, 20_000_000: cycles an action command is held.
- `ROUTE_INIT`, all HALT: packed `ROUTE_LEN`×3-bit table contents loaded at reset. Entry 0 is in the LSBs.
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: begin the route from entry 0. Sampled only in IDLE/DONE.
- `dir_code` in 4: steering code from `DirectionControl`.
- `wr_en` in 1: route table write strobe.
- `wr_addr` in log2(`ROUTE_LEN`): table index.
- `wr_data` in 3: action code.
- `direction` out 1: 1 = forwards, 0 = backwards. Drives `Direction` on `DirectionControl`.
- `motor_cmd` out 4: steering code to the motor driver.
- `busy` out 1: high in FOLLOW/EXECUTE/TURN.
- `done` out 1: high in DONE.
- `step_idx` out log2(`ROUTE_LEN`): index of the next route entry.

## Operation
- Steering codes are unchanged from `DirectionControl`: PROCEED 0000, VEER_R 1001, HARD_R 1010, 90_R 1011, VEER_L 0101, HARD_L 0110, 90_L 0111, STOP 1111.
- Action codes: 000 STRAIGHT, 001 LEFT, 010 RIGHT, 011 REVERSE, 100 HALT. Codes 101–111 are treated as HALT.
- Reset:
  - state IDLE, `motor_cmd`=1111, `direction`=1, `busy`=0, `done`=0, `step_idx`=0.
  - stop counter and turn counter = 0.
  - table = `ROUTE_INIT`.
- Table writes take effect only in IDLE or DONE. Writes in any other state are dropped.
- States:
  - **IDLE**: `motor_cmd`=STOP. On `start`: go to FOLLOW, set `step_idx`=0 and `direction`=1.
  - **FOLLOW**: `motor_cmd` <= `dir_code` every cycle.
    - Stop counter increments while `dir_code`==1111 and clears on any other code.
    - When the counter reaches `SETTLE_TICKS`, go to EXECUTE and clear the counter.
  - **EXECUTE** (one cycle): read table[`step_idx`].
    - STRAIGHT: `motor_cmd`=0000.
    - LEFT: `motor_cmd`=0111.
    - RIGHT: `motor_cmd`=1011.
    - REVERSE: toggle `direction`, `motor_cmd`=0000.
    - For each of the four actions above: go to TURN with turn counter 0.
    - HALT: `motor_cmd`=1111, go to DONE. `step_idx` is not advanced.
  - **TURN**: hold `motor_cmd` and increment the turn counter.
    - When the counter reaches `TURN_TICKS`-1, `step_idx` advances, the stop counter clears, and the next state is taken.
    - Next state is FOLLOW if the advanced index did not wrap. If it wrapped to 0 (last entry executed), go to DONE.
  - **DONE**: `motor_cmd`=STOP, `done`=1. On `start`: behaves as in IDLE (go to FOLLOW, `step_idx`=0, `direction`=1).
- Boundary rules:
  - `start` in FOLLOW/EXECUTE/TURN is ignored.
  - `wr_en` and `start` in the same IDLE/DONE cycle: the write lands first. An EXECUTE on that entry sees the new value.
  - `rst` in any state returns to the reset values on the next edge. The table is reloaded from `ROUTE_INIT`.
  - `dir_code` changes during TURN are ignored.

## Timing
- FOLLOW passthrough latency: 1 cycle, `dir_code` → `motor_cmd`.
- Intersection detect: when `dir_code` first reads STOP at cycle t and stays STOP, EXECUTE occurs at cycle t+`SETTLE_TICKS`.
- Action output: the action code appears on `motor_cmd` the cycle after EXECUTE and holds for `TURN_TICKS` cycles. Passthrough resumes on the next cycle.
- Flag timing: `busy`/`done` are registered and change in the same cycle as the state.
- `direction` toggles one cycle after a REVERSE EXECUTE.

## Structure
- Shared package `fury_pkg` holds:
  - steering code constants, reused by `DirectionControl`;
  - action code constants;
  - the state encoding.
- Sub-module `tick_counter`: parameterised width, `clear`/`en` inputs, `hit` at a terminal count. Instantiated twice, once for the stop counter and once for the turn counter.
- The table is a register array of `ROUTE_LEN`×3 bits. No RAM inference is required.

## Test plan
All cases use `SETTLE_TICKS`=4, `TURN_TICKS`=8.
- **Reset:** assert `rst` mid-TURN → next cycle `motor_cmd`=1111, `direction`=1, `busy`=0, `step_idx`=0, table = `ROUTE_INIT`.
- **Passthrough:** `start`, then `dir_code`=1010, 0110, 0000 → `motor_cmd` follows with 1-cycle lag. Three STOPs then 0000 → no EXECUTE.
- **Left turn:** table[0]=001, 4 consecutive STOPs → `motor_cmd`=0111 for exactly 8 cycles, then passthrough resumes, `step_idx`=1.
- **Reverse:** table[0]=011, STOP×4 → `direction` goes 0 and `motor_cmd`=0000 for 8 cycles. table[1]=100 → DONE, `done`=1, `motor_cmd`=1111.
- **Write guard:** `wr_en` during FOLLOW to entry 0 is dropped. Write in IDLE coincident with `start` is applied.
- **Wrap:** `ROUTE_LEN`=2, table = {000, 000}, two intersections → DONE after the second TURN, `step_idx`=0. `start` while busy is ignored.

Source files
------------

// File: rtl/fury_pkg.sv
// Shared steering/action codes and sequencer state encoding; no latency, no flow control.
// Steering values match DirectionControl so both blocks decode the motor bus identically.
package fury_pkg;

  typedef enum logic [3:0] {
    STEER_PROCEED = 4'b0000,
    STEER_VEER_L  = 4'b0101,
    STEER_HARD_L  = 4'b0110,
    STEER_90_L    = 4'b0111,
    STEER_VEER_R  = 4'b1001,
    STEER_HARD_R  = 4'b1010,
    STEER_90_R    = 4'b1011,
    STEER_STOP    = 4'b1111
  } steer_t;

  typedef enum logic [2:0] {
    ACT_STRAIGHT = 3'b000,
    ACT_LEFT     = 3'b001,
    ACT_RIGHT    = 3'b010,
    ACT_REVERSE  = 3'b011,
    ACT_HALT     = 3'b100
  } act_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FOLLOW,
    ST_EXECUTE,
    ST_TURN,
    ST_DONE
  } seq_state_t;

  // Unassigned action codes fall into the default arm and stop the robot.
  function automatic logic [3:0] action_cmd(input logic [2:0] act);
    logic [3:0] cmd;
    case (act)
      ACT_STRAIGHT: cmd = STEER_PROCEED;
      ACT_REVERSE:  cmd = STEER_PROCEED;
      ACT_LEFT:     cmd = STEER_90_L;
      ACT_RIGHT:    cmd = STEER_90_R;
      default:      cmd = STEER_STOP;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Cycle counter with combinational hit on the enabled cycle that reaches TERMINAL.
// No backpressure; clear wins over en, and the count restarts from zero after a hit.
module tick_counter #(
  parameter int unsigned      W        = 8,
  parameter logic [W-1:0]     TERMINAL = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic hit
);

  logic [W-1:0] count_q;

  assign hit = en && !clear && (count_q == TERMINAL);

  always_ff @(posedge clk) begin
    if (rst || clear || hit) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/route_sequencer.sv
// Route-table mission controller: 1-cycle dir_code passthrough, actions held TURN_TICKS cycles.
// No backpressure; table writes outside IDLE/DONE and start while busy are dropped.
module route_sequencer
  import fury_pkg::*;
#(
  parameter int unsigned             ROUTE_LEN    = 8,
  parameter int unsigned             SETTLE_TICKS = 100_000,
  parameter int unsigned             TURN_TICKS   = 20_000_000,
  parameter logic [ROUTE_LEN*3-1:0]  ROUTE_INIT   = {ROUTE_LEN{3'b100}},
  localparam int unsigned            AW           = $clog2(ROUTE_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    dir_code,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_data,
  output logic          direction,
  output logic [3:0]    motor_cmd,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] step_idx
);

  localparam int unsigned SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
  localparam int unsigned TW = (TURN_TICKS > 1) ? $clog2(TURN_TICKS) : 1;

  seq_state_t    state_q, state_d;
  logic [3:0]    motor_d;
  logic          dir_d;
  logic [AW-1:0] step_d;
  logic [2:0]    route_q [ROUTE_LEN];
  logic [2:0]    act;
  logic          table_open, stop_en, stop_hit, turn_hit;

  assign table_open = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign stop_en    = (state_q == ST_FOLLOW) && (dir_code == STEER_STOP);
  assign act        = route_q[step_idx];

  // Any non-STOP code, or leaving FOLLOW, restarts the intersection debounce.
  tick_counter #(.W(SW), .TERMINAL(SW'(SETTLE_TICKS - 1))) u_stop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (!stop_en),
    .en    (stop_en),
    .hit   (stop_hit)
  );

  tick_counter #(.W(TW), .TERMINAL(TW'(TURN_TICKS - 1))) u_turn_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == ST_EXECUTE),
    .en    (state_q == ST_TURN),
    .hit   (turn_hit)
  );

  always_comb begin
    state_d = state_q;
    motor_d = motor_cmd;
    dir_d   = direction;
    step_d  = step_idx;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        motor_d = STEER_STOP;
        if (start) begin
          state_d = ST_FOLLOW;
          step_d  = '0;
          dir_d   = 1'b1;
        end
      end
      ST_FOLLOW: begin
        motor_d = dir_code;
        if (stop_hit) state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        motor_d = action_cmd(act);
        if (act == ACT_REVERSE) dir_d = !direction;
        state_d = (act > ACT_REVERSE) ? ST_DONE : ST_TURN;
      end
      ST_TURN: begin
        // Exit edge reloads motor_cmd so passthrough resumes with no dead cycle.
        if (turn_hit) begin
          step_d = step_idx + AW'(1);
          if (step_idx == AW'(ROUTE_LEN - 1)) begin
            state_d = ST_DONE;
            motor_d = STEER_STOP;
          end else begin
            state_d = ST_FOLLOW;
            motor_d = dir_code;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      motor_cmd <= STEER_STOP;
      direction <= 1'b1;
      step_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      motor_cmd <= motor_d;
      direction <= dir_d;
      step_idx  <= step_d;
      busy      <= (state_d == ST_FOLLOW) || (state_d == ST_EXECUTE) || (state_d == ST_TURN);
      done      <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROUTE_LEN; i++) begin
        route_q[i] <= ROUTE_INIT[i*3 +: 3];
      end
    end else if (wr_en && table_open) begin
      route_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_route_sequencer.sv
// Directed bench for route_sequencer: an 8-entry instance for turns, reverse, guards and reset,
// plus a 2-entry instance for route wrap-around.
module tb_route_sequencer;

  localparam int TRN = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_start = 1'b0;
  logic [3:0] a_dir = 4'b0000;
  logic       a_wr_en = 1'b0;
  logic [2:0] a_wr_addr = 3'd0;
  logic [2:0] a_wr_data = 3'd0;
  logic       a_direction, a_busy, a_done;
  logic [3:0] a_motor;
  logic [2:0] a_step;

  logic       b_start = 1'b0;
  logic [3:0] b_dir = 4'b0000;
  logic       b_wr_en = 1'b0;
  logic [0:0] b_wr_addr = 1'b0;
  logic [2:0] b_wr_data = 3'd0;
  logic       b_direction, b_busy, b_done;
  logic [3:0] b_motor;
  logic [0:0] b_step;

  int checks = 0;
  int errors = 0;

  route_sequencer #(
    .ROUTE_LEN(8), .SETTLE_TICKS(4), .TURN_TICKS(TRN),
    .ROUTE_INIT({{7{3'b100}}, 3'b001})
  ) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .dir_code(a_dir),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .direction(a_direction), .motor_cmd(a_motor), .busy(a_busy),
    .done(a_done), .step_idx(a_step)
  );

  route_sequencer #(
    .ROUTE_LEN(2), .SETTLE_TICKS(4), .TURN_TICKS(TRN),
    .ROUTE_INIT(6'b000_000)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .dir_code(b_dir),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .direction(b_direction), .motor_cmd(b_motor), .busy(b_busy),
    .done(b_done), .step_idx(b_step)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    chk("rst_motor", a_motor, 4'b1111);
    chk("rst_direction", 4'(a_direction), 4'd1);
    chk("rst_busy", 4'(a_busy), 4'd0);
    chk("rst_done", 4'(a_done), 4'd0);
    chk("rst_step", 4'(a_step), 4'd0);

    // Passthrough with one-cycle lag
    a_start = 1'b1; cyc(1); a_start = 1'b0;
    chk("start_busy", 4'(a_busy), 4'd1);
    a_dir = 4'b1010; cyc(1); chk("pt_hard_r", a_motor, 4'b1010);
    a_dir = 4'b0110; cyc(1); chk("pt_hard_l", a_motor, 4'b0110);
    a_dir = 4'b0000; cyc(1); chk("pt_proceed", a_motor, 4'b0000);
    a_dir = 4'b1111; cyc(3); chk("pt_stop", a_motor, 4'b1111);
    a_dir = 4'b0000; cyc(1);
    chk("short_stop_motor", a_motor, 4'b0000);
    chk("short_stop_busy", 4'(a_busy), 4'd1);

    // Left turn from ROUTE_INIT entry 0; dir_code during TURN must be ignored
    a_dir = 4'b1111; cyc(4);
    chk("exec_cycle_motor", a_motor, 4'b1111);
    a_dir = 4'b1001;
    for (int i = 0; i < TRN; i++) begin
      cyc(1);
      chk("left_hold", a_motor, 4'b0111);
    end
    chk("left_step_during_turn", 4'(a_step), 4'd0);
    cyc(1);
    chk("left_resume", a_motor, 4'b1001);
    chk("left_step", 4'(a_step), 4'd1);
    chk("left_busy", 4'(a_busy), 4'd1);

    // Write in FOLLOW is dropped: entry 1 stays HALT
    a_wr_en = 1'b1; a_wr_addr = 3'd1; a_wr_data = 3'b000; cyc(1); a_wr_en = 1'b0;
    a_dir = 4'b1111; cyc(4); a_dir = 4'b0000; cyc(1);
    chk("guard_done", 4'(a_done), 4'd1);
    chk("guard_motor", a_motor, 4'b1111);
    chk("guard_busy", 4'(a_busy), 4'd0);
    chk("guard_step", 4'(a_step), 4'd1);

    // Write coincident with start lands; entry 0 becomes REVERSE
    a_wr_en = 1'b1; a_wr_addr = 3'd0; a_wr_data = 3'b011; a_start = 1'b1;
    cyc(1);
    a_wr_en = 1'b0; a_start = 1'b0;
    chk("restart_step", 4'(a_step), 4'd0);
    chk("restart_done", 4'(a_done), 4'd0);
    a_dir = 4'b1111; cyc(4); a_dir = 4'b0110;
    chk("rev_dir_exec", 4'(a_direction), 4'd1);
    cyc(1);
    chk("rev_direction", 4'(a_direction), 4'd0);
    chk("rev_motor", a_motor, 4'b0000);
    cyc(TRN - 1);
    chk("rev_hold_end", a_motor, 4'b0000);
    cyc(1);
    chk("rev_resume", a_motor, 4'b0110);
    chk("rev_step", 4'(a_step), 4'd1);
    a_dir = 4'b1111; cyc(4); a_dir = 4'b0000; cyc(1);
    chk("rev_halt_done", 4'(a_done), 4'd1);
    chk("rev_halt_motor", a_motor, 4'b1111);
    chk("rev_halt_direction", 4'(a_direction), 4'd0);

    // Reset in the middle of a REVERSE turn, then confirm table reload
    a_start = 1'b1; cyc(1); a_start = 1'b0;
    a_dir = 4'b1111; cyc(4); a_dir = 4'b0000; cyc(3);
    chk("mid_turn_busy", 4'(a_busy), 4'd1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("rst2_motor", a_motor, 4'b1111);
    chk("rst2_direction", 4'(a_direction), 4'd1);
    chk("rst2_busy", 4'(a_busy), 4'd0);
    chk("rst2_step", 4'(a_step), 4'd0);
    a_start = 1'b1; cyc(1); a_start = 1'b0;
    a_dir = 4'b1111; cyc(4); a_dir = 4'b0000; cyc(1);
    chk("reload_left", a_motor, 4'b0111);
    chk("reload_direction", 4'(a_direction), 4'd1);

    // Two-entry route wraps to DONE; start while busy ignored
    b_start = 1'b1; cyc(1); b_start = 1'b0;
    b_dir = 4'b1111; cyc(4); b_dir = 4'b0000; cyc(1);
    chk("wrap_turn1_motor", b_motor, 4'b0000);
    b_start = 1'b1; cyc(1); b_start = 1'b0;
    chk("wrap_turn_start_busy", 4'(b_busy), 4'd1);
    cyc(TRN - 2);
    chk("wrap_turn1_step", 4'(b_step), 4'd0);
    cyc(1);
    chk("wrap_follow_step", 4'(b_step), 4'd1);
    chk("wrap_follow_done", 4'(b_done), 4'd0);
    b_start = 1'b1; cyc(1); b_start = 1'b0;
    chk("wrap_follow_start_step", 4'(b_step), 4'd1);
    b_dir = 4'b1111; cyc(4); b_dir = 4'b0000; cyc(1);
    cyc(TRN - 1);
    chk("wrap_turn2_busy", 4'(b_busy), 4'd1);
    chk("wrap_turn2_done", 4'(b_done), 4'd0);
    cyc(1);
    chk("wrap_done", 4'(b_done), 4'd1);
    chk("wrap_busy", 4'(b_busy), 4'd0);
    chk("wrap_step", 4'(b_step), 4'd0);
    chk("wrap_motor", b_motor, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
